vc_arbiter_ctrl: RTL and testbench

//  Controller for the two virtual-channel FIFOs (VC0, VC1) and one downstream FIFO.
//  - Sequences the configuration phase: drives active-low FIFO init, latches thresholds.
//  - Arbitrates reads: VC0 and VC1 pops share one downstream push path.
//  - Stalls on downstream back-pressure.

---
 rtl/vc_arbiter_if.sv | 46 ++++
 rtl/vc_arbiter_ctrl.sv | 141 ++++++++++++++
 tb/tb_vc_arbiter_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_arbiter_if.sv
// vc_arbiter_if: bundles the FIFO-facing signals of the VC arbiter controller.
// master = controller side, slave = FIFO / configuration side.
interface vc_arbiter_if #(
   parameter int DATA_WIDTH = 6,
   parameter int UMB_WIDTH  = 4
);
   // configuration and control
   logic                  init;
   logic [UMB_WIDTH-1:0]  umb_vc0_cfg;
   logic [UMB_WIDTH-1:0]  umb_vc1_cfg;
   logic [UMB_WIDTH-1:0]  umb_down_cfg;
   // virtual-channel FIFOs
   logic                  empty_vc0;
   logic                  empty_vc1;
   logic [DATA_WIDTH-1:0] data_vc0;
   logic [DATA_WIDTH-1:0] data_vc1;
   // downstream FIFO status
   logic                  almost_full_dn;
   logic                  full_dn;
   // controller outputs
   logic                  fifo_init_n;
   logic [UMB_WIDTH-1:0]  umb_vc0;
   logic [UMB_WIDTH-1:0]  umb_vc1;
   logic [UMB_WIDTH-1:0]  umb_down;
   logic                  pop_vc0;
   logic                  pop_vc1;
   logic                  push_dn;
   logic [DATA_WIDTH-1:0] data_dn;
   logic [1:0]            state;

   modport master (
      input  init, umb_vc0_cfg, umb_vc1_cfg, umb_down_cfg,
      input  empty_vc0, empty_vc1, data_vc0, data_vc1,
      input  almost_full_dn, full_dn,
      output fifo_init_n, umb_vc0, umb_vc1, umb_down,
      output pop_vc0, pop_vc1, push_dn, data_dn, state
   );

   modport slave (
      output init, umb_vc0_cfg, umb_vc1_cfg, umb_down_cfg,
      output empty_vc0, empty_vc1, data_vc0, data_vc1,
      output almost_full_dn, full_dn,
      input  fifo_init_n, umb_vc0, umb_vc1, umb_down,
      input  pop_vc0, pop_vc1, push_dn, data_dn, state
   );
endinterface

// File: rtl/vc_arbiter_ctrl.sv
// vc_arbiter_ctrl: configuration sequencer and read arbiter for two VC FIFOs
// feeding one downstream FIFO. Pops are combinational; the downstream push
// follows one cycle later to line up with the FIFOs' registered read data.
// Optional feature macro: VC_WRR_EN -- weighted round robin (WEIGHT_VC0
// consecutive VC0 grants, then one VC1 grant). Undefined: strict VC0 priority.
module vc_arbiter_ctrl #(
   parameter int DATA_WIDTH = 6,
   parameter int UMB_WIDTH  = 4,
   parameter int WEIGHT_VC0 = 3
) (
   input  logic         clk,
   input  logic         reset,   // synchronous, active-low
   vc_arbiter_if.master bus
);

   localparam logic [1:0] S_RESET  = 2'd0;
   localparam logic [1:0] S_INIT   = 2'd1;
   localparam logic [1:0] S_IDLE   = 2'd2;
   localparam logic [1:0] S_ACTIVE = 2'd3;

   // the grant counter is 3 bits wide, so the weight must fit in 1..7
   if (WEIGHT_VC0 < 1 || WEIGHT_VC0 > 7) begin : g_weight_check
      $error("WEIGHT_VC0 must be in 1..7");
   end

   logic [1:0]           state_q, state_d;
   logic [UMB_WIDTH-1:0] umb_vc0_q, umb_vc1_q, umb_down_q;
   logic                 push_q;   // a pop happened last cycle
   logic                 sel_q;    // that pop was from VC1
   logic                 stall;
   logic                 can_pop;
   logic                 pop0, pop1;

   assign stall   = bus.almost_full_dn | bus.full_dn;
   assign can_pop = (state_q == S_ACTIVE) & ~bus.init & ~stall;

`ifdef VC_WRR_EN
   localparam logic [2:0] GC_MAX = 3'(WEIGHT_VC0);

   logic [2:0] gc_q, gc_d;
   logic       force_vc1;

   // VC0 has used up its weight and VC1 has something waiting
   assign force_vc1 = (gc_q == GC_MAX) & ~bus.empty_vc1;
   assign pop0      = can_pop & ~bus.empty_vc0 & ~force_vc1;
   assign pop1      = can_pop & ~bus.empty_vc1 & (force_vc1 | bus.empty_vc0);

   // grant counter: counts VC0 pops, saturates at the weight, clears on a VC1 pop
   always_comb begin
      gc_d = gc_q;
      if (state_q == S_RESET || state_q == S_INIT) begin
         gc_d = 3'd0;
      end else if (pop1) begin
         gc_d = 3'd0;
      end else if (pop0 && gc_q != GC_MAX) begin
         gc_d = gc_q + 3'd1;
      end
   end

   // grant counter register
   always_ff @(posedge clk) begin
      if (!reset) begin
         gc_q <= 3'd0;
      end else begin
         gc_q <= gc_d;
      end
   end
`else
   assign pop0 = can_pop & ~bus.empty_vc0;
   assign pop1 = can_pop & ~bus.empty_vc1 & bus.empty_vc0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: init always pulls back to INIT; ACTIVE drains until both VCs are empty
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:  state_d = S_INIT;
         S_INIT:   if (!bus.init) state_d = S_IDLE;
         S_IDLE: begin
            if (bus.init) begin
               state_d = S_INIT;
            end else if (!bus.empty_vc0 || !bus.empty_vc1) begin
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (bus.init) begin
               state_d = S_INIT;
            end else if (bus.empty_vc0 && bus.empty_vc1 && !pop0 && !pop1) begin
               state_d = S_IDLE;
            end
         end
         default:  state_d = S_RESET;
      endcase
   end

   // thresholds track the config inputs only in INIT; push pipeline follows the pops
   always_ff @(posedge clk) begin
      if (!reset) begin
         umb_vc0_q  <= '0;
         umb_vc1_q  <= '0;
         umb_down_q <= '0;
         push_q     <= 1'b0;
         sel_q      <= 1'b0;
      end else begin
         if (state_q == S_INIT) begin
            umb_vc0_q  <= bus.umb_vc0_cfg;
            umb_vc1_q  <= bus.umb_vc1_cfg;
            umb_down_q <= bus.umb_down_cfg;
         end
         push_q <= pop0 | pop1;
         sel_q  <= pop1;
      end
   end

   // FSM outputs and downstream data mux
   always_comb begin
      bus.fifo_init_n = (state_q == S_IDLE) || (state_q == S_ACTIVE);
      bus.umb_vc0     = umb_vc0_q;
      bus.umb_vc1     = umb_vc1_q;
      bus.umb_down    = umb_down_q;
      bus.pop_vc0     = pop0;
      bus.pop_vc1     = pop1;
      bus.push_dn     = push_q;
      bus.data_dn     = '0;
      if (push_q) begin
         bus.data_dn = sel_q ? bus.data_vc1 : bus.data_vc0;
      end
      bus.state       = state_q;
   end

endmodule

// File: tb/tb_vc_arbiter_ctrl.sv
// tb_vc_arbiter_ctrl: random and directed stimulus against a reference model
// of the arbiter; downstream words are checked through a scoreboard queue.
module tb_vc_arbiter_ctrl;
   localparam int DW = 6;
   localparam int UW = 4;
   localparam int WT = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vc_arbiter_if #(.DATA_WIDTH(DW), .UMB_WIDTH(UW)) bus ();

   vc_arbiter_ctrl #(.DATA_WIDTH(DW), .UMB_WIDTH(UW), .WEIGHT_VC0(WT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [DW-1:0] word;
      int            cyc;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;
   exp_t          sb[$];
   logic [DW-1:0] fifo0[$], fifo1[$], ld0[$], ld1[$];
   logic [DW-1:0] word_ctr = '0;

   // reference model: state numbering RESET=0 INIT=1 IDLE=2 ACTIVE=3
   int            m_state = 0;
   int            m_gc    = 0;
   logic [UW-1:0] m_umb0  = '0, m_umb1 = '0, m_umbd = '0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end
   endtask

   // environment: VC FIFO models plus cycle-level reference of the controller
   initial begin
      bit has0, has1, go, exp0, exp1, cap0, cap1, clr;
      bus.empty_vc0 = 1'b1;
      bus.empty_vc1 = 1'b1;
      bus.data_vc0  = '0;
      bus.data_vc1  = '0;
      forever begin
         @(negedge clk);
         check("state", int'(bus.state), m_state);
         check("fifo_init_n", int'(bus.fifo_init_n), (m_state >= 2) ? 1 : 0);
         check("umb_vc0", int'(bus.umb_vc0), int'(m_umb0));
         check("umb_vc1", int'(bus.umb_vc1), int'(m_umb1));
         check("umb_down", int'(bus.umb_down), int'(m_umbd));

         has0 = fifo0.size() > 0;
         has1 = fifo1.size() > 0;
         go   = (m_state == 3) && !bus.init && !bus.almost_full_dn && !bus.full_dn;
         exp0 = 1'b0;
         exp1 = 1'b0;
         if (go) begin
`ifdef VC_WRR_EN
            if (has1 && (m_gc == WT || !has0)) exp1 = 1'b1;
            else if (has0)                     exp0 = 1'b1;
`else
            if (has0)      exp0 = 1'b1;
            else if (has1) exp1 = 1'b1;
`endif
         end
         check("pop_vc0", int'(bus.pop_vc0), int'(exp0));
         check("pop_vc1", int'(bus.pop_vc1), int'(exp1));
         check("pop_excl", int'(bus.pop_vc0 & bus.pop_vc1), 0);
         // a reset edge right after the pop discards the word
         if (reset && (exp0 || exp1)) begin
            sb.push_back('{exp0 ? fifo0[0] : fifo1[0], cyc + 1});
         end
         cap0 = bus.pop_vc0;
         cap1 = bus.pop_vc1;
         clr  = (m_state < 2);

         if (!reset) begin
            m_state = 0;
            m_gc    = 0;
            m_umb0  = '0;
            m_umb1  = '0;
            m_umbd  = '0;
         end else begin
            if (m_state == 1) begin
               m_umb0 = bus.umb_vc0_cfg;
               m_umb1 = bus.umb_vc1_cfg;
               m_umbd = bus.umb_down_cfg;
            end
            if (m_state <= 1 || exp1) m_gc = 0;
            else if (exp0 && m_gc < WT) m_gc++;
            case (m_state)
               0: m_state = 1;
               1: if (!bus.init) m_state = 2;
               2: if (bus.init) m_state = 1; else if (has0 || has1) m_state = 3;
               default: if (bus.init) m_state = 1; else if (!has0 && !has1) m_state = 2;
            endcase
         end

         @(posedge clk);
         #1;
         cyc++;
         if (cap0 && fifo0.size() > 0) bus.data_vc0 = fifo0.pop_front();
         if (cap1 && fifo1.size() > 0) bus.data_vc1 = fifo1.pop_front();
         if (clr) begin
            fifo0.delete();
            fifo1.delete();
         end
         while (ld0.size() > 0) fifo0.push_back(ld0.pop_front());
         while (ld1.size() > 0) fifo1.push_back(ld1.pop_front());
         bus.empty_vc0 = (fifo0.size() == 0);
         bus.empty_vc1 = (fifo1.size() == 0);
      end
   end

   // monitor: every downstream push must match the oldest expected word
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("push_missing", 0, int'(sb[0].word));
            void'(sb.pop_front());
         end
         if (bus.push_dn) begin
            if (sb.size() == 0) begin
               check("push_unexpected", int'(bus.data_dn), -1);
            end else begin
               e = sb.pop_front();
               check("push_cycle", cyc, e.cyc);
               check("push_data", int'(bus.data_dn), int'(e.word));
            end
         end else begin
            check("data_dn_idle", int'(bus.data_dn), 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic load(input int vc, input int n);
      repeat (n) begin
         if (vc == 0) ld0.push_back(word_ctr);
         else         ld1.push_back(word_ctr);
         word_ctr = word_ctr + 1'b1;
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int k = 0;
      bit done;
      done = 1'b0;
      while (!done && k < budget) begin
         tick(1);
         k++;
         done = (fifo0.size() == 0) && (fifo1.size() == 0) && (ld0.size() == 0) &&
                (ld1.size() == 0) && (sb.size() == 0) && (m_state == 2);
      end
      check(name, int'(done), 1);
   endtask

   // stimulus
   initial begin
      reset                = 1'b0;
      bus.init             = 1'b0;
      bus.umb_vc0_cfg      = '0;
      bus.umb_vc1_cfg      = '0;
      bus.umb_down_cfg     = '0;
      bus.almost_full_dn   = 1'b0;
      bus.full_dn          = 1'b0;
      tick(2);

      // configuration phase
      reset            = 1'b1;
      bus.init         = 1'b1;
      bus.umb_vc0_cfg  = 4'd2;
      bus.umb_vc1_cfg  = 4'd3;
      bus.umb_down_cfg = 4'd4;
      tick(3);
      check("cfg_umb_vc0", int'(bus.umb_vc0), 2);
      check("cfg_umb_vc1", int'(bus.umb_vc1), 3);
      check("cfg_umb_down", int'(bus.umb_down), 4);
      bus.init = 1'b0;

      // VC0 burst of three words
      load(0, 3);
      wait_idle("idle_after_vc0", 50);

      // both VCs loaded
      load(0, 4);
      load(1, 4);
      wait_idle("idle_after_both", 60);

      // back-pressure mid-burst
      load(0, 8);
      tick(3);
      bus.almost_full_dn = 1'b1;
      tick(3);
      bus.almost_full_dn = 1'b0;
      wait_idle("idle_after_stall", 60);

      // init while active
      load(0, 6);
      load(1, 2);
      tick(4);
      bus.init = 1'b1;
      tick(2);
      bus.init = 1'b0;
      wait_idle("idle_after_init", 60);

      // reset mid-burst
      load(0, 6);
      tick(4);
      reset = 1'b0;
      tick(2);
      reset    = 1'b1;
      bus.init = 1'b1;
      tick(2);
      bus.init = 1'b0;
      tick(2);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) load(0, int'($urandom_range(3)));
         if ($urandom_range(3) == 0) load(1, int'($urandom_range(3)));
         bus.almost_full_dn = ($urandom_range(4) == 0);
         bus.full_dn        = ($urandom_range(9) == 0);
         bus.init           = ($urandom_range(39) == 0);
         if (bus.init) begin
            bus.umb_vc0_cfg  = UW'($urandom);
            bus.umb_vc1_cfg  = UW'($urandom);
            bus.umb_down_cfg = UW'($urandom);
         end
         reset = ($urandom_range(99) != 0);
         tick(1);
      end
      reset              = 1'b1;
      bus.init           = 1'b0;
      bus.almost_full_dn = 1'b0;
      bus.full_dn        = 1'b0;
      wait_idle("idle_after_random", 300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
